button_clock_frontend: RTL and testbench

- Front-end for push-button-driven logic: synchronises and debounces NUM_PB raw active-low buttons, and produces per-button level, press and release outputs.
- Also generates a registered step-clock output OUTCLK. OUTCLK follows either a free-running slow source (SRC_CLK) or a debounced "step" button, chosen by a debounced "alt-select" button.
- Single CLK domain. Downstream logic uses PB_STATE as synchronous resets/controls and OUTCLK as a slow clock/enable.

---
 rtl/button_clock_frontend.sv | 103 ++++++++++
 tb/tb_button_clock_frontend.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_clock_frontend.sv
// Push-button front end: per-button sync + debounce with press/release pulses,
// plus a registered step clock. Define CLKSEL_GLITCHFREE_EN for guarded source switching.

module button_clock_frontend_db #(
    parameter int CNT_W = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic pb_raw,
    output logic state,
    output logic down,
    output logic up
);
    // Sync flops hold raw polarity, so they reset to 1 (released).
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic             pressed;

    assign pressed = ~sync2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            state <= 1'b0;
            down  <= 1'b0;
            up    <= 1'b0;
        end else begin
            sync1 <= pb_raw;
            sync2 <= sync1;
            down  <= 1'b0;
            up    <= 1'b0;
            if (pressed == state) begin
                cnt <= '0;
            end else if (!(&cnt)) begin
                cnt <= cnt + 1'b1;
            end else begin
                state <= ~state;
                cnt   <= '0;
                down  <= ~state;
                up    <= state;
            end
        end
    end
endmodule

module button_clock_frontend #(
    parameter int NUM_PB   = 4,
    parameter int DB_CNT_W = 16,
    parameter int STEP_IDX = 0,
    parameter int ALT_IDX  = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_PB-1:0] PB,
    input  logic              SRC_CLK,
    output logic [NUM_PB-1:0] PB_STATE,
    output logic [NUM_PB-1:0] PB_DOWN,
    output logic [NUM_PB-1:0] PB_UP,
    output logic              OUTCLK,
    output logic              SEL
);
    button_clock_frontend_db #(.CNT_W(DB_CNT_W)) u_db [NUM_PB-1:0] (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .pb_raw (PB),
        .state  (PB_STATE),
        .down   (PB_DOWN),
        .up     (PB_UP)
    );

    logic src_s1, src_s2;
    logic cur_src, tgt;

    assign cur_src = SEL ? PB_STATE[STEP_IDX] : src_s2;
    assign tgt     = PB_STATE[ALT_IDX];

`ifdef CLKSEL_GLITCHFREE_EN
    // Only hand over while both the output and the incoming source are low.
    logic nxt_src;
    assign nxt_src = tgt ? PB_STATE[STEP_IDX] : src_s2;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_s1 <= 1'b0;
            src_s2 <= 1'b0;
            OUTCLK <= 1'b0;
            SEL    <= 1'b0;
        end else begin
            src_s1 <= SRC_CLK;
            src_s2 <= src_s1;
            OUTCLK <= cur_src;
`ifdef CLKSEL_GLITCHFREE_EN
            if (tgt != SEL && !OUTCLK && !nxt_src)
                SEL <= tgt;
`else
            SEL <= tgt;
`endif
        end
    end
endmodule

// File: tb/tb_button_clock_frontend.sv
// Randomised bench for button_clock_frontend against a duration-based debounce model.
module tb_button_clock_frontend;
    localparam int NP = 4;
    localparam int W  = 4;

    logic          CLK, RST_N, SRC_CLK, OUTCLK, SEL;
    logic [NP-1:0] PB, PB_STATE, PB_DOWN, PB_UP;

    button_clock_frontend #(.NUM_PB(NP), .DB_CNT_W(W), .STEP_IDX(0), .ALT_IDX(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .PB(PB), .SRC_CLK(SRC_CLK),
        .PB_STATE(PB_STATE), .PB_DOWN(PB_DOWN), .PB_UP(PB_UP),
        .OUTCLK(OUTCLK), .SEL(SEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Model: pressed samples reach the debouncer two edges late; a level that
    // disagrees with the state for 2^W consecutive edges flips it.
    logic [NP-1:0] pq[$];
    logic          sq[$];
    int            run[NP];
    logic [NP-1:0] m_st, m_dn, m_up;
    logic          m_out, m_sel;

    task automatic model_init();
        pq.delete(); pq.push_back('0); pq.push_back('0);
        sq.delete(); sq.push_back(1'b0); sq.push_back(1'b0);
        for (int i = 0; i < NP; i++) run[i] = 0;
        m_st = '0; m_dn = '0; m_up = '0; m_out = 1'b0; m_sel = 1'b0;
    endtask

    task automatic model_step(input logic [NP-1:0] pb, input logic src);
        logic [NP-1:0] seen, st_pre;
        logic          srcs, tgt, nsel;
        seen = pq.pop_front(); pq.push_back(~pb);
        srcs = sq.pop_front(); sq.push_back(src);
        st_pre = m_st;
        m_dn = '0; m_up = '0;
        for (int i = 0; i < NP; i++) begin
            if (seen[i] != m_st[i]) begin
                run[i]++;
                if (run[i] == (1 << W)) begin
                    m_st[i] = ~m_st[i];
                    run[i]  = 0;
                    if (m_st[i]) m_dn[i] = 1'b1; else m_up[i] = 1'b1;
                end
            end else begin
                run[i] = 0;
            end
        end
        tgt  = st_pre[1];
        nsel = m_sel;
`ifdef CLKSEL_GLITCHFREE_EN
        if (tgt != m_sel && !m_out && !(tgt ? st_pre[0] : srcs)) nsel = tgt;
`else
        nsel = tgt;
`endif
        m_out = m_sel ? st_pre[0] : srcs;
        m_sel = nsel;
    endtask

    // One clock: drive after the falling edge, model on the rising edge, compare on the next fall.
    task automatic cyc(input logic [NP-1:0] pb, input logic src);
        PB = pb; SRC_CLK = src;
        @(posedge CLK);
        model_step(pb, src);
        @(negedge CLK);
        chk("pb_state", PB_STATE, m_st);
        chk("pb_down",  PB_DOWN,  m_dn);
        chk("pb_up",    PB_UP,    m_up);
        chk("outclk",   OUTCLK,   m_out);
        chk("sel",      SEL,      m_sel);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (3) begin
            PB = NP'($urandom); SRC_CLK = 1'($urandom);
            @(negedge CLK);
            chk("rst_state", PB_STATE, 0);
            chk("rst_down",  PB_DOWN,  0);
            chk("rst_up",    PB_UP,    0);
            chk("rst_out",   OUTCLK,   0);
            chk("rst_sel",   SEL,      0);
        end
        model_init();
        PB = '1; SRC_CLK = 1'b0;
        RST_N = 1'b1;
    endtask

    initial begin
        int            lat, ndn, nrise;
        logic          prev_out, src;
        logic [NP-1:0] pbr;
        RST_N = 1'b0; PB = '1; SRC_CLK = 1'b0;
        @(negedge CLK);
        do_reset();
        repeat (20) cyc('1, 1'b0);

        // Clean press and release of button 2.
        lat = -1; ndn = 0;
        for (int e = 0; e < 30; e++) begin
            cyc(4'b1011, 1'b0);
            if (PB_STATE[2] && lat < 0) lat = e;
            if (PB_DOWN[2]) ndn++;
        end
        chk("press_lat", lat, 17);
        chk("press_cnt", ndn, 1);
        lat = -1; ndn = 0;
        for (int e = 0; e < 30; e++) begin
            cyc(4'b1111, 1'b0);
            if (!PB_STATE[2] && lat < 0) lat = e;
            if (PB_UP[2]) ndn++;
        end
        chk("release_lat", lat, 17);
        chk("release_cnt", ndn, 1);

        // Bounce on button 3, then a steady press.
        ndn = 0;
        for (int c = 0; c < 60; c++) begin
            cyc({((c / 5) % 2 == 0) ? 1'b0 : 1'b1, 3'b111}, 1'b0);
            if (PB_DOWN[3]) ndn++;
        end
        chk("bounce_dn", ndn, 0);
        lat = -1;
        for (int e = 0; e < 30; e++) begin
            cyc(4'b0111, 1'b0);
            if (PB_DOWN[3] && lat < 0) lat = e;
        end
        chk("bounce_lat", lat, 17);
        repeat (25) cyc('1, 1'b0);

        // Free-running source, period 8.
        for (int c = 0; c < 64; c++) cyc('1, ((c / 4) % 2) == 1);

        // Manual stepping: hold ALT, pulse STEP three times.
        repeat (25) cyc(4'b1101, 1'b0);
        chk("man_sel", SEL, 1);
        nrise = 0; prev_out = OUTCLK;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 20; c++) begin
                cyc(4'b1100, 1'b0);
                if (OUTCLK && !prev_out) nrise++;
                prev_out = OUTCLK;
            end
            for (int c = 0; c < 20; c++) begin
                cyc(4'b1101, 1'b0);
                if (OUTCLK && !prev_out) nrise++;
                prev_out = OUTCLK;
            end
        end
        chk("man_pulses", nrise, 3);

        // Switch back to the running source; then ALT pressed mid-source.
        for (int c = 0; c < 60; c++) cyc('1, ((c / 4) % 2) == 1);
        for (int c = 0; c < 60; c++) cyc(4'b1101, ((c / 4) % 2) == 1);
        for (int c = 0; c < 60; c++) cyc(4'b1100, ((c / 3) % 2) == 1);
        for (int c = 0; c < 40; c++) cyc('1, ((c / 4) % 2) == 1);

        // Random phase with a reset in the middle.
        pbr = '1; src = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) pbr[$urandom_range(0, NP-1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) src = ~src;
            cyc(pbr, src);
            if (c == 1500) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
